// File: rtl/clink_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clink_axi_pkg
// Description : Shared constants and FSM state types for the Camera Link
//               AXI register block.
// Revision    : 1.0 - initial release
// ============================================================================
package clink_axi_pkg;

    localparam logic [7:0] ADDR_UART        = 8'h00;
    localparam logic [7:0] ADDR_CC          = 8'h10;
    localparam logic [7:0] ADDR_UART_VALID  = 8'h20;
    localparam logic [7:0] ADDR_CLINK_READY = 8'h30;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int VALID_BIT_NONEMPTY   = 0;
    localparam int VALID_BIT_TX_PENDING = 1;
    localparam int VALID_BIT_OVERFLOW   = 2;
    localparam int VALID_COUNT_LSB      = 8;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/clink_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : clink_rx_fifo
// Description : Synchronous byte FIFO for the camera UART receive path.
// Revision    : 1.0 - initial release
// ============================================================================
module clink_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // A full FIFO still accepts a push when a pop frees the head slot.
    assign w_push = i_push && (!o_full || i_pop);
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_clink_regs.sv
`default_nettype none
// ============================================================================
// Module      : axi_clink_regs
// Description : AXI responder for Camera Link UART TX/RX and CC registers.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_clink_regs
    import clink_axi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 7,
    parameter int AXI_DATA_WIDTH = 128,
    parameter int RX_FIFO_DEPTH  = 16
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [7:0]                    uart_tx_data,
    output logic                          uart_tx_valid,
    input  logic                          uart_tx_ready,
    input  logic [7:0]                    uart_rx_data,
    input  logic                          uart_rx_valid,
    output logic [3:0]                    cc_out,
    input  logic                          clink_ready
);

    localparam int CW = $clog2(RX_FIFO_DEPTH) + 1;

    wr_state_t          r_wr_state, w_wr_state_next;
    rd_state_t          r_rd_state, w_rd_state_next;
    logic               w_wr_accept, w_rd_accept;
    logic [1:0]         r_bresp, r_rresp;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic [3:0]         r_cc;
    logic               r_tx_pending;
    logic [7:0]         r_tx_data;
    logic               r_overflow;
    logic [15:0]        w_rd_word;
    logic [1:0]         w_rd_resp;
    logic               w_rd_pop, w_ovf_clear, w_ovf_set;
    logic [7:0]         w_fifo_head;
    logic               w_fifo_full, w_fifo_empty;
    logic [CW-1:0]      w_fifo_count;
    logic               w_unused;

    assign w_unused = ^{s_axi_wdata[AXI_DATA_WIDTH-1:8], s_axi_wstrb};

    assign s_axi_awready = w_wr_accept;
    assign s_axi_wready  = w_wr_accept;
    assign s_axi_bvalid  = (r_wr_state == W_RESP);
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = w_rd_accept;
    assign s_axi_rvalid  = (r_rd_state == R_DATA);
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;
    assign uart_tx_valid = r_tx_pending;
    assign uart_tx_data  = r_tx_data;
    assign cc_out        = r_cc;

    clink_rx_fifo #(
        .DEPTH (RX_FIFO_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk         (s_axi_aclk),
        .rst_n       (s_axi_aresetn),
        .i_push      (uart_rx_valid),
        .i_push_data (uart_rx_data),
        .i_pop       (w_rd_pop),
        .o_head      (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    always_comb begin
        w_wr_state_next = r_wr_state;
        w_wr_accept     = 1'b0;
        case (r_wr_state)
            W_IDLE: if (s_axi_awvalid && s_axi_wvalid) begin
                w_wr_accept     = 1'b1;
                w_wr_state_next = W_RESP;
            end
            W_RESP: if (s_axi_bready) w_wr_state_next = W_IDLE;
            default: w_wr_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        w_rd_state_next = r_rd_state;
        w_rd_accept     = 1'b0;
        case (r_rd_state)
            R_IDLE: if (s_axi_arvalid) begin
                w_rd_accept     = 1'b1;
                w_rd_state_next = R_DATA;
            end
            R_DATA: if (s_axi_rready) w_rd_state_next = R_IDLE;
            default: w_rd_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_wr_state <= W_IDLE;
            r_rd_state <= R_IDLE;
        end else begin
            r_wr_state <= w_wr_state_next;
            r_rd_state <= w_rd_state_next;
        end
    end

    // Read decode; an empty UART_RX read returns 0 without popping.
    always_comb begin
        w_rd_word   = '0;
        w_rd_resp   = RESP_OKAY;
        w_rd_pop    = 1'b0;
        w_ovf_clear = 1'b0;
        if (s_axi_araddr == AXI_ADDR_WIDTH'(ADDR_UART)) begin
            w_rd_word[7:0] = w_fifo_empty ? 8'h00 : w_fifo_head;
            w_rd_pop       = w_rd_accept && !w_fifo_empty;
        end else if (s_axi_araddr == AXI_ADDR_WIDTH'(ADDR_UART_VALID)) begin
            w_rd_word[VALID_BIT_NONEMPTY]   = !w_fifo_empty;
            w_rd_word[VALID_BIT_TX_PENDING] = r_tx_pending;
            w_rd_word[VALID_BIT_OVERFLOW]   = r_overflow;
            w_rd_word[VALID_COUNT_LSB +: 8] = 8'(w_fifo_count);
            w_ovf_clear = w_rd_accept;
        end else if (s_axi_araddr == AXI_ADDR_WIDTH'(ADDR_CLINK_READY)) begin
            w_rd_word[0] = clink_ready;
        end else begin
            w_rd_resp = RESP_SLVERR;
        end
    end

    assign w_ovf_set = uart_rx_valid && w_fifo_full && !w_rd_pop;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_overflow <= 1'b0;
        end else begin
            if (w_rd_accept) begin
                r_rdata <= AXI_DATA_WIDTH'(w_rd_word);
                r_rresp <= w_rd_resp;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_bresp      <= RESP_OKAY;
            r_cc         <= '0;
            r_tx_pending <= 1'b0;
            r_tx_data    <= '0;
        end else begin
            if (r_tx_pending && uart_tx_ready) begin
                r_tx_pending <= 1'b0;
            end
            if (w_wr_accept) begin
                if (s_axi_awaddr == AXI_ADDR_WIDTH'(ADDR_UART)) begin
                    if (r_tx_pending) begin
                        r_bresp <= RESP_SLVERR;
                    end else begin
                        r_bresp      <= RESP_OKAY;
                        r_tx_pending <= 1'b1;
                        r_tx_data    <= s_axi_wdata[7:0];
                    end
                end else if (s_axi_awaddr == AXI_ADDR_WIDTH'(ADDR_CC)) begin
                    r_bresp <= RESP_OKAY;
                    r_cc    <= s_axi_wdata[3:0];
                end else begin
                    r_bresp <= RESP_SLVERR;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_clink_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_clink_regs
// Description : Directed self-checking bench for axi_clink_regs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_clink_regs;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [6:0]   awaddr = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [127:0] wdata = '0;
    logic [15:0]  wstrb = '1;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [6:0]   araddr = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic [7:0]   rx_data = '0;
    logic         rx_valid = 1'b0;
    logic [3:0]   cc_out;
    logic         clink_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [3:0]   cc_at_hs;
    logic         bvalid_at_hs;
    logic         rvalid_at_hs;
    logic [1:0]   resp;
    logic [127:0] data;

    always #5 clk = ~clk;

    axi_clink_regs #(
        .AXI_ADDR_WIDTH (7),
        .AXI_DATA_WIDTH (128),
        .RX_FIFO_DEPTH  (16)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .uart_tx_data  (tx_data),
        .uart_tx_valid (tx_valid),
        .uart_tx_ready (tx_ready),
        .uart_rx_data  (rx_data),
        .uart_rx_valid (rx_valid),
        .cc_out        (cc_out),
        .clink_ready   (clink_ready)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [6:0] a, input logic [127:0] d, output logic [1:0] r);
        int n;
        @(negedge clk);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        n = 0;
        while (!(awready && wready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 20) chk("aw_w_handshake_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        cc_at_hs = cc_out;
        bvalid_at_hs = bvalid;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) chk("bvalid_timeout", 1'b0, 1'b1);
        r = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [6:0] a, output logic [127:0] d, output logic [1:0] r);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 20) chk("ar_handshake_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        rvalid_at_hs = rvalid;
        rready = 1'b1;
        n = 0;
        while (!rvalid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) chk("rvalid_timeout", 1'b0, 1'b1);
        d = rdata;
        r = rresp;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_awready", awready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_cc_out", cc_out, 4'h0);
        chk("rst_rdata", rdata, 128'h0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // CC write
        axi_write(7'h10, 128'h5, resp);
        chk("cc_after_hs", cc_at_hs, 4'b0101);
        chk("cc_bvalid_after_hs", bvalid_at_hs, 1'b1);
        chk("cc_bresp", resp, 2'b00);

        // UART TX handshake
        axi_write(7'h00, 128'hA5, resp);
        chk("tx1_bresp", resp, 2'b00);
        chk("tx1_valid", tx_valid, 1'b1);
        chk("tx1_data", tx_data, 8'hA5);
        axi_write(7'h00, 128'h3C, resp);
        chk("tx2_bresp_slverr", resp, 2'b10);
        chk("tx2_data_kept", tx_data, 8'hA5);
        chk("tx2_valid_kept", tx_valid, 1'b1);
        @(negedge clk); tx_ready = 1'b1;
        @(negedge clk); tx_ready = 1'b0;
        #1;
        chk("tx_valid_cleared", tx_valid, 1'b0);

        // RX FIFO basic
        rx_byte(8'h11);
        rx_byte(8'h22);
        axi_read(7'h20, data, resp);
        chk("rxvalid_two", data, 128'h0201);
        chk("rxvalid_rvalid_after_hs", rvalid_at_hs, 1'b1);
        axi_read(7'h00, data, resp);
        chk("rx_pop1", data, 128'h11);
        axi_read(7'h00, data, resp);
        chk("rx_pop2", data, 128'h22);
        axi_read(7'h00, data, resp);
        chk("rx_empty_data", data, 128'h0);
        chk("rx_empty_resp", resp, 2'b00);

        // Overflow
        for (int i = 0; i < 17; i++) rx_byte(8'h40 + 8'(i));
        axi_read(7'h20, data, resp);
        chk("ovf_status", data, 128'h1005);
        axi_read(7'h20, data, resp);
        chk("ovf_cleared", data, 128'h1001);
        axi_read(7'h00, data, resp);
        chk("ovf_head_oldest", data, 128'h40);

        // clink_ready and unmapped
        clink_ready = 1'b1;
        axi_read(7'h30, data, resp);
        chk("clink_ready_data", data, 128'h1);
        chk("clink_ready_resp", resp, 2'b00);
        axi_read(7'h40, data, resp);
        chk("unmapped_rd_data", data, 128'h0);
        chk("unmapped_rd_resp", resp, 2'b10);
        axi_write(7'h40, 128'hF, resp);
        chk("unmapped_wr_resp", resp, 2'b10);
        chk("unmapped_wr_cc", cc_out, 4'b0101);

        // R channel back-pressure then async reset mid-hold
        @(negedge clk);
        araddr = 7'h30; arvalid = 1'b1; rready = 1'b0;
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rvalid", rvalid, 1'b1);
            chk("hold_rdata", rdata, 128'h1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rvalid", rvalid, 1'b0);
        chk("arst_rdata", rdata, 128'h0);
        chk("arst_cc_out", cc_out, 4'h0);
        chk("arst_tx_data", tx_data, 8'h00);
        @(negedge clk); rst_n = 1'b1; rready = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_no_rvalid", rvalid, 1'b0);
        chk("post_rst_no_bvalid", bvalid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
